clock_divider_prog: RTL and testbench

CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

---
 rtl/clock_divider_pkg.sv | 12 +
 rtl/clock_divider_chan.sv | 90 +++++++++
 rtl/clock_divider_prog.sv | 55 +++++
 tb/tb_clock_divider_prog.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and mode encoding for the programmable clock divider.
package clock_divider_pkg;

  localparam int MAX_CHANNELS  = 8;
  localparam int DEFAULT_DIV_C = 3;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } div_mode_t;

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: wrap counter, shadow/active configuration and output shaping.
module clock_divider_chan
  import clock_divider_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             we,
  input  logic [WIDTH-1:0] div,
  input  logic             mode,
  output logic             clock_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_sh;
  logic [WIDTH-1:0] last;
  div_mode_t        mode_act;
  div_mode_t        mode_sh;
  div_mode_t        next_mode;
  logic             wrap;
  logic             apply;
  logic             out_nxt;

  // div_act is never zero, so the decrement cannot underflow.
  assign last  = div_act - ONE;
  assign wrap  = enable && (count >= last);
  assign apply = pending && (!enable || wrap);

  // A mode change takes effect on the applying wrap itself.
  always_comb begin
    out_nxt   = clock_out;
    next_mode = apply ? mode_sh : mode_act;
    if (enable) begin
      if (wrap) begin
        if (next_mode == MODE_PULSE) out_nxt = 1'b1;
        else if (mode_act == MODE_PULSE) out_nxt = 1'b0;
        else out_nxt = ~clock_out;
      end else if (mode_act == MODE_PULSE) begin
        out_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      tick      <= 1'b0;
      clock_out <= 1'b0;
      pending   <= 1'b0;
      div_act   <= RESET_DIV;
      div_sh    <= RESET_DIV;
      mode_act  <= MODE_SQUARE;
      mode_sh   <= MODE_SQUARE;
    end else begin
      if (!enable) begin
        count <= '0;
        tick  <= 1'b0;
      end else if (wrap) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + ONE;
        tick  <= 1'b0;
      end
      clock_out <= out_nxt;
      // Active takes the old shadow here; a same-cycle write waits for the next wrap.
      if (apply) begin
        div_act  <= div_sh;
        mode_act <= mode_sh;
      end
      if (we) begin
        div_sh  <= div;
        mode_sh <= div_mode_t'(mode);
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider with write decode and rejected-write flag.
module clock_divider_prog
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] cfg_pending,
  output logic                cfg_err
);

  localparam logic [SEL_W:0] CHAN_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic cfg_ok;

  // Extra select bit keeps the range check exact for non-power-of-two counts.
  assign cfg_ok = (cfg_div != '0) && ({1'b0, cfg_sel} < CHAN_LIMIT);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) cfg_err <= 1'b0;
    else          cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic chan_we;
    assign chan_we = cfg_we && cfg_ok && (cfg_sel == SEL_W'(ch));

    clock_divider_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable[ch]),
      .we        (chan_we),
      .div       (cfg_div),
      .mode      (cfg_mode),
      .clock_out (clock_out[ch]),
      .tick      (tick[ch]),
      .pending   (cfg_pending[ch])
    );
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Randomised and directed bench for clock_divider_prog against a cycle-level behavioural model.
module tb_clock_divider_prog;

  localparam int CH      = 3;
  localparam int W       = 28;
  localparam int SW      = 2;
  localparam int DEF_DIV = 3;

  logic          clock_in = 1'b0;
  logic          reset_n;
  logic [CH-1:0] enable;
  logic          cfg_we;
  logic [SW-1:0] cfg_sel;
  logic [W-1:0]  cfg_div;
  logic          cfg_mode;
  logic [CH-1:0] clock_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] cfg_pending;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  int m_d[CH];
  int m_sd[CH];
  int m_pos[CH];
  bit m_pulse[CH];
  bit m_spulse[CH];
  bit m_pend[CH];
  bit m_out[CH];
  bit m_tick[CH];
  bit m_err;

  int cyc;
  int last_rise[CH];
  int period[CH];
  int tick_cnt[CH];
  int rise_cnt[CH];
  bit prev_out[CH];

  // Three channels so the 2-bit select can name a channel that does not exist.
  clock_divider_prog #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .clock_out   (clock_out),
    .tick        (tick),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  always #5 clock_in = ~clock_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int ch = 0; ch < CH; ch++) begin
      m_d[ch]      = DEF_DIV;
      m_sd[ch]     = DEF_DIV;
      m_pos[ch]    = 0;
      m_pulse[ch]  = 1'b0;
      m_spulse[ch] = 1'b0;
      m_pend[ch]   = 1'b0;
      m_out[ch]    = 1'b0;
      m_tick[ch]   = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  // m_pos counts enabled cycles in the current period; reaching D ends the period.
  function automatic void modelStep(input logic [CH-1:0] en, input logic we,
                                    input logic [SW-1:0] sel, input logic [W-1:0] div,
                                    input logic mode);
    bit ok;
    ok = we && (div != 0) && (int'(sel) < CH);
    m_err = we && !ok;
    for (int ch = 0; ch < CH; ch++) begin
      bit wrap;
      bit apply;
      bit was_pulse;
      wrap      = 1'b0;
      was_pulse = m_pulse[ch];
      if (en[ch]) begin
        m_pos[ch]++;
        if (m_pos[ch] >= m_d[ch]) begin
          wrap      = 1'b1;
          m_pos[ch] = 0;
        end
      end else begin
        m_pos[ch] = 0;
      end
      apply      = m_pend[ch] && (!en[ch] || wrap);
      m_tick[ch] = wrap;
      if (apply) begin
        m_d[ch]     = m_sd[ch];
        m_pulse[ch] = m_spulse[ch];
      end
      if (en[ch]) begin
        if (m_pulse[ch]) m_out[ch] = wrap;
        else if (wrap)   m_out[ch] = was_pulse ? 1'b0 : !m_out[ch];
      end
      if (ok && int'(sel) == ch) begin
        m_sd[ch]     = int'(div);
        m_spulse[ch] = mode;
        m_pend[ch]   = 1'b1;
      end else if (apply) begin
        m_pend[ch] = 1'b0;
      end
    end
  endfunction

  task automatic compareAll();
    for (int ch = 0; ch < CH; ch++) begin
      checkOutput($sformatf("clock_out[%0d]", ch), 32'(clock_out[ch]), 32'(m_out[ch]));
      checkOutput($sformatf("tick[%0d]", ch), 32'(tick[ch]), 32'(m_tick[ch]));
      checkOutput($sformatf("cfg_pending[%0d]", ch), 32'(cfg_pending[ch]), 32'(m_pend[ch]));
    end
    checkOutput("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic trackEdges();
    for (int ch = 0; ch < CH; ch++) begin
      if (tick[ch]) tick_cnt[ch]++;
      if (clock_out[ch] && !prev_out[ch]) begin
        if (last_rise[ch] >= 0) period[ch] = cyc - last_rise[ch];
        last_rise[ch] = cyc;
        rise_cnt[ch]++;
      end
      prev_out[ch] = clock_out[ch];
    end
  endtask

  task automatic clearStats();
    for (int ch = 0; ch < CH; ch++) begin
      last_rise[ch] = -1;
      period[ch]    = 0;
      tick_cnt[ch]  = 0;
      rise_cnt[ch]  = 0;
    end
  endtask

  // Entered and left at a falling edge; inputs are sampled by the following rising edge.
  task automatic applyStimulus(input logic [CH-1:0] en, input logic we, input logic [SW-1:0] sel,
                               input logic [W-1:0] div, input logic mode);
    compareAll();
    trackEdges();
    enable   = en;
    cfg_we   = we;
    cfg_sel  = sel;
    cfg_div  = div;
    cfg_mode = mode;
    @(posedge clock_in);
    modelStep(en, we, sel, div, mode);
    @(negedge clock_in);
    cyc++;
  endtask

  task automatic doReset();
    compareAll();
    reset_n = 1'b0;
    modelReset();
    #1;
    compareAll();
    checkOutput("reset_all_zero", 32'({clock_out, tick, cfg_pending, cfg_err}), 32'd0);
    for (int ch = 0; ch < CH; ch++) prev_out[ch] = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit found;
    reset_n  = 1'b0;
    enable   = '0;
    cfg_we   = 1'b0;
    cfg_sel  = '0;
    cfg_div  = '0;
    cfg_mode = 1'b0;
    cyc      = 0;
    modelReset();
    clearStats();
    for (int ch = 0; ch < CH; ch++) prev_out[ch] = 1'b0;

    @(negedge clock_in);
    compareAll();
    @(negedge clock_in);
    reset_n = 1'b1;
    $display("[TB] reset released");

    repeat (3) applyStimulus(3'b000, 1'b0, '0, '0, 1'b0);
    clearStats();
    repeat (20) applyStimulus(3'b001, 1'b0, '0, '0, 1'b0);
    checkOutput("default_period", 32'(period[0]), 32'd6);
    checkOutput("default_ticks", 32'(tick_cnt[0]), 32'd6);
    checkOutput("ch1_idle_rises", 32'(rise_cnt[1]), 32'd0);

    applyStimulus(3'b001, 1'b0, '0, '0, 1'b0);
    applyStimulus(3'b001, 1'b1, 2'd0, 28'd5, 1'b0);
    checkOutput("div5_pending", 32'(cfg_pending[0]), 32'd1);
    clearStats();
    repeat (40) applyStimulus(3'b001, 1'b0, '0, '0, 1'b0);
    checkOutput("div5_period", 32'(period[0]), 32'd10);
    checkOutput("div5_pending_clear", 32'(cfg_pending[0]), 32'd0);

    applyStimulus(3'b011, 1'b1, 2'd1, 28'd4, 1'b1);
    clearStats();
    repeat (40) applyStimulus(3'b011, 1'b0, '0, '0, 1'b0);
    checkOutput("pulse4_period", 32'(period[1]), 32'd4);
    checkOutput("pulse4_highs", 32'(tick_cnt[1]), 32'd10);
    checkOutput("ch0_unperturbed", 32'(period[0]), 32'd10);

    applyStimulus(3'b011, 1'b1, 2'd0, 28'd0, 1'b0);
    checkOutput("err_div0", 32'(cfg_err), 32'd1);
    checkOutput("err_div0_pending", 32'(cfg_pending), 32'd0);
    applyStimulus(3'b011, 1'b1, 2'd3, 28'd5, 1'b0);
    checkOutput("err_sel3", 32'(cfg_err), 32'd1);
    checkOutput("err_sel3_pending", 32'(cfg_pending), 32'd0);
    applyStimulus(3'b011, 1'b0, '0, '0, 1'b0);
    checkOutput("err_one_cycle", 32'(cfg_err), 32'd0);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_pos[0] == m_d[0] - 1) found = 1'b1;
      else applyStimulus(3'b011, 1'b0, '0, '0, 1'b0);
    end
    checkOutput("wrap_search", 32'(found), 32'd1);
    applyStimulus(3'b011, 1'b1, 2'd0, 28'd7, 1'b0);
    applyStimulus(3'b011, 1'b1, 2'd0, 28'd2, 1'b0);
    checkOutput("b2b_pending", 32'(cfg_pending[0]), 32'd1);
    clearStats();
    repeat (30) applyStimulus(3'b011, 1'b0, '0, '0, 1'b0);
    checkOutput("b2b_period", 32'(period[0]), 32'd4);

    for (int i = 0; i < 400; i++) begin
      logic [CH-1:0] en;
      logic          we;
      en = ($urandom_range(0, 9) == 0) ? CH'($urandom) : 3'b111;
      we = ($urandom_range(0, 7) == 0);
      applyStimulus(en, we, SW'($urandom_range(0, 3)), W'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)));
    end

    applyStimulus(3'b111, 1'b1, 2'd0, 28'd6, 1'b1);
    checkOutput("reset_pending_set", 32'(cfg_pending[0]), 32'd1);
    doReset();
    clearStats();
    repeat (20) applyStimulus(3'b001, 1'b0, '0, '0, 1'b0);
    checkOutput("post_reset_period", 32'(period[0]), 32'd6);
    checkOutput("post_reset_ticks", 32'(tick_cnt[0]), 32'd6);
    compareAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
